// File: rtl/matrix_result_drain_pkg.sv
// Shared definitions for the blocked matrix-multiply datapath.
//   state_t    : drain FSM states (IDLE, STREAM)
//   idx_width  : index width for n items, max(1, $clog2(n)); also used by
//                the multiply engine and the loader
package matrix_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_result_drain_if.sv
// Valid/ready element stream carrying one result element with its row/col
// tags and a last-element flag.
//   out_valid : element presented (master -> slave)
//   out_ready : consumer accepts the element (slave -> master)
//   out_data  : element value
//   out_row   : row index of the element
//   out_col   : column index of the element
//   out_last  : final element of the matrix
interface matrix_result_drain_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ROW_W  = 1,
    parameter int unsigned COL_W  = 1
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              out_last;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_result_drain.sv
// Snapshots the multiply engine's flat result bus on a done_in pulse and
// streams it out element by element in row-major order.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   done_in      : one-cycle pulse, result_in valid in that cycle
//   result_in    : flat R*C result, element (r,c) at ((r*C+c)*W) +: W
//   busy         : a matrix is held or being streamed
//   overrun      : sticky, a done_in was dropped while streaming
//   stream       : element stream (master side)
module matrix_result_drain
    import matrix_pkg::*;
#(
    parameter int unsigned OUTPUT_DATA_WIDTH      = 16,
    parameter int unsigned FIRST_MATRIX_ROW_SIZE  = 3,
    parameter int unsigned SECOND_MATRIX_COL_SIZE = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic done_in,
    input  logic [FIRST_MATRIX_ROW_SIZE*SECOND_MATRIX_COL_SIZE*OUTPUT_DATA_WIDTH-1:0] result_in,
    output logic busy,
    output logic overrun,
    matrix_result_drain_if.master stream
);

    localparam int unsigned W  = OUTPUT_DATA_WIDTH;
    localparam int unsigned R  = FIRST_MATRIX_ROW_SIZE;
    localparam int unsigned C  = SECOND_MATRIX_COL_SIZE;
    localparam int unsigned RW = idx_width(R);
    localparam int unsigned CW = idx_width(C);

    localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(C - 1);

    state_t            state;
    logic [R*C*W-1:0]  snap;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              streaming;
    logic              handshake;
    logic              at_last;
    int unsigned       elem_base;

    assign streaming = (state == STREAM);
    assign handshake = streaming && stream.out_ready;
    assign at_last   = (row == ROW_LAST) && (col == COL_LAST);

    always_comb begin
        elem_base = (32'(row) * C + 32'(col)) * W;
    end

    // Outputs come straight from the state/index registers; data and last
    // are forced to zero outside STREAM so idle outputs read as zero.
    assign busy             = streaming;
    assign stream.out_valid = streaming;
    assign stream.out_row   = row;
    assign stream.out_col   = col;
    assign stream.out_last  = streaming && at_last;
    assign stream.out_data  = streaming ? snap[elem_base +: W] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (done_in) begin
                        snap  <= result_in;
                        row   <= '0;
                        col   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (at_last) begin
                            row <= '0;
                            col <= '0;
                            // A capture landing on the final handshake chains
                            // straight into the next matrix without a bubble.
                            if (done_in) begin
                                snap <= result_in;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                    if (done_in && !(handshake && at_last)) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_drain.sv
module tb_matrix_result_drain;

    localparam int unsigned W = 16;
    localparam int unsigned R = 2;
    localparam int unsigned C = 3;

    logic clock;
    logic reset;
    logic done_in;
    logic [R*C*W-1:0] result_in;
    logic busy;
    logic overrun;

    matrix_result_drain_if #(.DATA_W(W), .ROW_W(1), .COL_W(2)) s ();

    matrix_result_drain #(
        .OUTPUT_DATA_WIDTH(W),
        .FIRST_MATRIX_ROW_SIZE(R),
        .SECOND_MATRIX_COL_SIZE(C)
    ) dut (
        .clock(clock),
        .reset(reset),
        .done_in(done_in),
        .result_in(result_in),
        .busy(busy),
        .overrun(overrun),
        .stream(s.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    // Behavioural model: a queue of the elements still owed to the consumer.
    typedef struct packed {
        logic [15:0] d;
        logic        r;
        logic [1:0]  c;
        logic        l;
    } elem_t;

    elem_t       mq[$];
    logic        m_ovr = 1'b0;
    logic [15:0] acc[$];
    logic        cmp_en = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_ovr = 1'b0;
        end else begin
            if (mq.size() != 0 && s.out_ready) begin
                acc.push_back(s.out_data);
                void'(mq.pop_front());
            end
            if (done_in) begin
                if (mq.size() == 0) begin
                    for (int r = 0; r < R; r++)
                        for (int c = 0; c < C; c++)
                            mq.push_back('{d: result_in[(r*C+c)*W +: W], r: 1'(r), c: 2'(c),
                                           l: (r == R-1) && (c == C-1)});
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("valid", 32'(s.out_valid), 32'(mq.size() != 0));
            chk("busy", 32'(busy), 32'(mq.size() != 0));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (mq.size() != 0) begin
                chk("data", 32'(s.out_data), 32'(mq[0].d));
                chk("row", 32'(s.out_row), 32'(mq[0].r));
                chk("col", 32'(s.out_col), 32'(mq[0].c));
                chk("last", 32'(s.out_last), 32'(mq[0].l));
            end
        end
    end

    task automatic load(input logic [15:0] base);
        for (int k = 0; k < R*C; k++) result_in[k*W +: W] = base + 16'(k);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_seq(input string nm, input int start, input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (start + i < acc.size()) chk(nm, 32'(acc[start+i]), 32'(base + 16'(i)));
            else chk(nm, 32'hFFFF_FFFF, 32'(base + 16'(i)));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        acc.delete();
    endtask

    localparam logic [7:0] BP_PAT = 8'b1110_1001;  // bit i = ready in cycle i: 1,0,0,1,0,1,1,1

    initial begin
        reset = 1'b1; done_in = 1'b0; result_in = '0; s.out_ready = 1'b1;
        // Reset: three cycles, all outputs zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            cmp_en = 1'b1;
            chk("rst_valid", 32'(s.out_valid), 0);
            chk("rst_data", 32'(s.out_data), 0);
            chk("rst_rowcol", 32'({s.out_row, s.out_col}), 0);
            chk("rst_last", 32'(s.out_last), 0);
            chk("rst_busy_ovr", 32'({busy, overrun}), 0);
        end
        reset = 1'b0;
        cyc(2);
        chk("idle_valid", 32'(s.out_valid), 0);

        // Basic stream.
        acc.delete();
        load(16'h0001); done_in = 1'b1;
        cyc(1); done_in = 1'b0;
        chk("lat_valid", 32'(s.out_valid), 1);
        chk("lat_data", 32'(s.out_data), 32'h0001);
        cyc(5);
        chk("basic_last_data", 32'(s.out_data), 32'h0006);
        chk("basic_last_flag", 32'(s.out_last), 1);
        chk("basic_last_rc", 32'({s.out_row, s.out_col}), 32'b110);
        cyc(1);
        chk("basic_busy_end", 32'(busy), 0);
        check_seq("basic_seq", 0, 16'h0001, 6);
        chk("basic_cnt", 32'(acc.size()), 6);

        // Backpressure.
        acc.delete();
        load(16'h0001); done_in = 1'b1;
        cyc(1); done_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s.out_ready = BP_PAT[i];
            cyc(1);
        end
        s.out_ready = 1'b1;
        cyc(4);
        check_seq("bp_seq", 0, 16'h0001, 6);
        chk("bp_cnt", 32'(acc.size()), 6);

        // Overrun: second done_in while the third element is presented.
        acc.delete();
        load(16'h0001); done_in = 1'b1;
        cyc(1); done_in = 1'b0;
        cyc(2);
        chk("ovr_third", 32'(s.out_data), 32'h0003);
        load(16'h00AA); done_in = 1'b1;
        cyc(1); done_in = 1'b0;
        chk("ovr_set", 32'(overrun), 1);
        cyc(8);
        check_seq("ovr_seq", 0, 16'h0001, 6);
        chk("ovr_cnt", 32'(acc.size()), 6);
        chk("ovr_sticky", 32'(overrun), 1);
        do_reset();
        chk("ovr_cleared", 32'(overrun), 0);

        // Back-to-back capture on the last handshake.
        load(16'h0001); done_in = 1'b1;
        cyc(1); done_in = 1'b0;
        cyc(5);
        chk("b2b_pre", 32'(s.out_data), 32'h0006);
        load(16'h0011); done_in = 1'b1;
        cyc(1); done_in = 1'b0;
        chk("b2b_valid", 32'(s.out_valid), 1);
        chk("b2b_data", 32'(s.out_data), 32'h0011);
        chk("b2b_rc", 32'({s.out_row, s.out_col}), 0);
        chk("b2b_ovr", 32'(overrun), 0);
        cyc(7);
        check_seq("b2b_seq1", 0, 16'h0001, 6);
        check_seq("b2b_seq2", 6, 16'h0011, 6);
        chk("b2b_cnt", 32'(acc.size()), 12);

        // Reset mid-stream after 0x0003 is accepted, with a coincident done_in.
        acc.delete();
        load(16'h0001); done_in = 1'b1;
        cyc(1); done_in = 1'b0;
        cyc(3);
        load(16'h00BB); done_in = 1'b1; reset = 1'b1;
        cyc(1); done_in = 1'b0; reset = 1'b0;
        chk("mrst_valid", 32'(s.out_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        check_seq("mrst_seq", 0, 16'h0001, 3);
        chk("mrst_cnt", 32'(acc.size()), 3);
        cyc(2);
        chk("mrst_idle", 32'(s.out_valid), 0);
        load(16'h0021); done_in = 1'b1;
        cyc(1); done_in = 1'b0;
        chk("restart_data", 32'(s.out_data), 32'h0021);
        chk("restart_rc", 32'({s.out_row, s.out_col}), 0);
        cyc(8);
        chk("restart_done", 32'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/matrix_result_drain.md
# matrix_result_drain

Serialises a completed result matrix from the blocked matrix-multiply engine into a valid/ready element stream. On the engine's one-cycle `done_in` pulse it snapshots the flat result bus, then emits elements in row-major order with row/column tags and a last flag. It sits between the multiply engine's `finals` bus and any downstream consumer: a DMA writer, a UART bridge or a checker.

## Interface
- `OUTPUT_DATA_WIDTH`, default 16, width of one result element.
- `FIRST_MATRIX_ROW_SIZE`, default 3, result rows (R), ≥1.
- `SECOND_MATRIX_COL_SIZE`, default 3, result columns (C), ≥1.
- `clock`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `done_in`  in  1  one-cycle pulse; `result_in` is valid in this cycle.
- `result_in`  in  R*C*OUTPUT_DATA_WIDTH  flat result. Element (r,c) is at bits `((r*C+c)*OUTPUT_DATA_WIDTH) +: OUTPUT_DATA_WIDTH`.
- `out_valid`  out  1  element presented.
- `out_ready`  in  1  consumer accepts the element.
- `out_data`  out  OUTPUT_DATA_WIDTH  element value.
- `out_row`  out  RW = max(1,$clog2(R))  row index of the element.
- `out_col`  out  CW = max(1,$clog2(C))  column index of the element.
- `out_last`  out  1  marks element (R-1,C-1).
- `busy`  out  1  a matrix is held or being streamed.
- `overrun`  out  1  sticky; set when a `done_in` is dropped.

## Operation
- The block has two states, IDLE and STREAM. Reset state is IDLE.
- IDLE:
  - On `done_in`, copy `result_in` into an internal R*C snapshot register.
  - Clear `row` and `col`, then go to STREAM.
- STREAM:
  - `out_valid`=1.
  - `out_data` = snapshot(row,col).
  - `out_last` = (row==R-1 && col==C-1).
- Handshake is `out_valid && out_ready`. On handshake:
  - `col` increments.
  - When `col`==C-1, `col` wraps to 0 and `row` increments.
  - On the last element, return to IDLE.
- `done_in` while in STREAM and not on the last handshake:
  - The capture is dropped and the snapshot is unchanged.
  - `overrun` is set to 1 and stays set until `reset`.
- `done_in` in the same cycle as the last-element handshake:
  - The capture is accepted and `row`/`col` are cleared.
  - State stays STREAM, so the new matrix streams with no bubble and `overrun` is not set.
- `busy` = (state==STREAM).
- No arithmetic is applied to data; elements pass through bit-exact. Index compares use full-width counters, with no modulo for non-power-of-2 R or C.
- R=1 or C=1 is legal. With R=C=1, each matrix is a single element with `out_last`=1.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `busy`=0, `overrun`=0, state IDLE.
- Reset asserted mid-stream: `out_valid` is 0 in the cycle after the reset edge and the partial matrix is discarded. A `done_in` coincident with `reset` is ignored.
- Latency: `done_in` in cycle N gives `out_valid`=1 with element (0,0) in cycle N+1.
- Throughput: one element per cycle while `out_ready`=1. A matrix takes R*C cycles minimum.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_row`, `out_col` and `out_last` hold stable. `out_valid` never drops without a handshake, except on reset.
- `out_valid` does not depend combinationally on `out_ready`. `out_data` is driven from registers via the index mux; there is no combinational path from `result_in`.

## Structure
- Shared package `matrix_pkg` holds:
  - the state enum (IDLE, STREAM);
  - an index-width helper function giving max(1,$clog2(n)), reused by the multiply engine and the future loader.
- Single module, with no sub-module. The row/col counter pair is inline.

## Test plan
- Reset: hold `reset` 3 cycles with `out_ready`=1. Required: every output is 0, and `out_valid` stays 0 with no `done_in`.
- Basic stream (R=2, C=3, W=16): pulse `done_in` in cycle N with elements 0x0001..0x0006 row-major, `out_ready`=1. Required:
  - cycles N+1..N+6 emit 1..6;
  - (row,col) sequence is (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
  - `out_last` is 1 only on 0x0006;
  - `busy` is 0 at N+7.
- Backpressure: same stimulus with `out_ready` pattern 1,0,0,1,0,1,1,1. Required: each element is held while ready=0, and the sequence is still 1..6 with no duplicates or skips.
- Overrun: pulse a second `done_in` carrying 0x00AA.. while the third element is presented. Required: stream stays 1..6 and `overrun`=1 persists until `reset`.
- Back-to-back: pulse `done_in` carrying 0x0011..0x0016 on the cycle 0x0006 handshakes. Required: 0x0011 appears the next cycle with `out_valid` continuous and `overrun`=0.
- Reset mid-stream: assert `reset` after 0x0003 is accepted. Required: `out_valid`=0 the next cycle, and a later `done_in` restarts at (0,0).
